uar_pkt_ctrl: RTL
=================

# uar_pkt_ctrl

Packet controller between the UART board receiver and the game logic. It detects start and end of each received frame from the receiver's `ready` line and validates the 162-bit board (81 cells × 2 bits). Accepted boards are latched and presented to the consumer with a valid/ack handshake. A watchdog recovers the receiver from stalled frames by pulsing its reset.

## Interface
- `DATA_W`, 162: board width; must be a multiple of `CELL_W`.
- `CELL_W`, 2: bits per cell.
- `TIMEOUT_CYC`, 1_600_000: max clk cycles `rx_ready` may stay low per frame.
- `RECOVER_CYC`, 4: cycles `rx_rst` is held high on timeout.

Ports:
- `clk_in` in 1: system clock (65 MHz).
- `rst_in` in 1: synchronous, active-high reset.
- `rx_ready` in 1: receiver ready; low while a frame is being read.
- `rx_data` in DATA_W: receiver board output, stable while `rx_ready` high.
- `rx_rst` out 1: receiver reset, `rst_in | (state==RECOVER)`.
- `brd_data` out DATA_W: last accepted board.
- `brd_valid` out 1: unacknowledged board available.
- `brd_ack` in 1: consumer takes board when `brd_valid & brd_ack`.
- `brd_changed` out 1: last accepted board differed from the previous accepted board.
- `overrun` out 1: sticky; a board was accepted while `brd_valid` was high with no ack that cycle.
- `pkt_cnt` out 16: accepted frames, wraps 65535→0.
- `err_cnt` out 8: rejected frames plus timeouts, saturates at 255.
- `busy` out 1: state != IDLE.

## Operation
- `rx_ready_q` is a register holding the previous `rx_ready`.
  - fall = `rx_ready_q & ~rx_ready`.
  - rise = `rx_ready & ~rx_ready_q`.
  - Reset value of `rx_ready_q` is 1.
- FSM states: IDLE, RECV, CHECK, RECOVER.
  - IDLE: on fall → RECV, `timer` cleared to 0.
  - RECV: `timer` increments each cycle (32-bit). On rise → CHECK. Otherwise, when `timer == TIMEOUT_CYC-1` → RECOVER and `err_cnt`++. Rise wins over timeout in the same cycle.
  - CHECK (1 cycle): validate `rx_data`. Invalid when any cell equals `2'b11`. → IDLE.
    - Valid frame: `brd_data <= rx_data`, `brd_changed <= (rx_data != brd_data)`, `pkt_cnt`++, `brd_valid <= 1`. Set `overrun` if `brd_valid & ~brd_ack`.
    - Invalid frame: `err_cnt`++; `brd_data`, `brd_valid` and `brd_changed` are unchanged.
  - RECOVER: `timer` counts 0..RECOVER_CYC-1 with `rx_rst` high → IDLE. `rx_ready` edges are ignored.
- Handshake: `brd_valid` clears on `brd_valid & brd_ack` unless CHECK accepts in the same cycle; in that case it stays 1 with the new data.
- `brd_ack` while `brd_valid` is low has no effect.
- Reset values:
  - state = IDLE.
  - `brd_data`, `brd_valid`, `brd_changed`, `overrun`, `pkt_cnt`, `err_cnt`, `timer` = 0.
  - `rx_rst` = 1 while `rst_in` is high.
- Reset mid-frame: the frame is discarded and the FSM returns to IDLE next cycle. The receiver is reset through `rx_rst`.

## Timing
- First cycle t with `rx_ready` high after low → CHECK at t+1 → `brd_valid`/`brd_data`/counters visible at t+2.
- Fall at cycle t → RECV at t+1, `timer` = 0 at t+1.
- Timeout: state is RECOVER when `timer` reaches TIMEOUT_CYC-1 in RECV + 1 cycle. `rx_rst` is high for exactly RECOVER_CYC cycles, then IDLE.
- All outputs are registered except `rx_rst` and `busy`.

## Configuration
- `UAR_CTRL_CELLCHK_EN` defined: the cell-value validation in CHECK is active as above.
- `UAR_CTRL_CELLCHK_EN` undefined: every completed frame is accepted. `err_cnt` counts timeouts only. No cell-compare logic is synthesized.

## Test plan
- Reset, then `rx_ready` 1→0→(100 cycles)→1 with `rx_data` all `2'b01` cells → `brd_valid`=1 two cycles after rise, `pkt_cnt`=1, `brd_changed`=1, `brd_data` matches `rx_data`.
- Same frame repeated, ack between frames → `pkt_cnt`=2, `brd_changed`=0; after `brd_ack`, `brd_valid`=0 next cycle.
- Frame with cell 40 = `2'b11`:
  - With the macro defined → `err_cnt`=1, `brd_valid` and `pkt_cnt` unchanged.
  - Without it → accepted.
- `rx_ready` held low for TIMEOUT_CYC+10 cycles (TIMEOUT_CYC=1000 in bench) → `rx_rst` high for exactly 4 cycles, `err_cnt`=1, `busy`=0 afterward.
- Two valid frames with no ack → `overrun`=1, `brd_data` = second frame. Ack coincident with CHECK accept → `brd_valid` stays 1.
- `rst_in` pulsed mid-RECV → all outputs return to reset values, `rx_rst`=1 during reset, the next frame is accepted normally.

Source files
------------

// File: rtl/uar_pkt_ctrl.sv
// rtl/uar_pkt_ctrl.sv - UART board packet controller: frame detect, validate, latch, watchdog
// Optional build macro UAR_CTRL_CELLCHK_EN enables rejection of frames containing an all-ones cell.
module uar_pkt_ctrl #(
  parameter int DATA_W      = 162,
  parameter int CELL_W      = 2,
  parameter int TIMEOUT_CYC = 1_600_000,
  parameter int RECOVER_CYC = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_rst,
  output logic [DATA_W-1:0] brd_data,
  output logic              brd_valid,
  input  logic              brd_ack,
  output logic              brd_changed,
  output logic              overrun,
  output logic [15:0]       pkt_cnt,
  output logic [7:0]        err_cnt,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RECV    = 2'd1;
  localparam logic [1:0] ST_CHECK   = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0] RECOVER_LAST = 32'(RECOVER_CYC - 1);

  if (DATA_W % CELL_W != 0) begin : g_bad_width
    $error("DATA_W must be a multiple of CELL_W");
  end

  logic [1:0]        state_q, state_d;
  logic [31:0]       timer_q, timer_d;
  logic              rx_ready_q, rx_ready_d;
  logic [DATA_W-1:0] brd_data_q, brd_data_d;
  logic              brd_valid_q, brd_valid_d;
  logic              brd_changed_q, brd_changed_d;
  logic              overrun_q, overrun_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic fall, rise, frame_ok;

  assign fall = rx_ready_q & ~rx_ready;
  assign rise = rx_ready & ~rx_ready_q;

`ifdef UAR_CTRL_CELLCHK_EN
  always_comb begin
    frame_ok = 1'b1;
    for (int i = 0; i < DATA_W / CELL_W; i++) begin
      if (rx_data[i*CELL_W +: CELL_W] == {CELL_W{1'b1}}) frame_ok = 1'b0;
    end
  end
`else
  assign frame_ok = 1'b1;
`endif

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    rx_ready_d    = rx_ready;
    brd_data_d    = brd_data_q;
    brd_valid_d   = brd_valid_q;
    brd_changed_d = brd_changed_q;
    overrun_d     = overrun_q;
    pkt_cnt_d     = pkt_cnt_q;
    err_cnt_d     = err_cnt_q;

    // Consumer handshake; a same-cycle accept in CHECK overrides this below.
    if (brd_valid_q && brd_ack) brd_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_RECV;
          timer_d = 32'd0;
        end
      end
      ST_RECV: begin
        timer_d = timer_q + 32'd1;
        if (rise) begin
          state_d = ST_CHECK;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d = ST_RECOVER;
          timer_d = 32'd0;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (frame_ok) begin
          brd_data_d    = rx_data;
          brd_changed_d = (rx_data != brd_data_q);
          pkt_cnt_d     = pkt_cnt_q + 16'd1;
          brd_valid_d   = 1'b1;
          if (brd_valid_q && !brd_ack) overrun_d = 1'b1;
        end else if (err_cnt_q != 8'hFF) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      default: begin
        timer_d = timer_q + 32'd1;
        if (timer_q == RECOVER_LAST) begin
          state_d = ST_IDLE;
          timer_d = 32'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= ST_IDLE;
      timer_q       <= 32'd0;
      rx_ready_q    <= 1'b1;
      brd_data_q    <= '0;
      brd_valid_q   <= 1'b0;
      brd_changed_q <= 1'b0;
      overrun_q     <= 1'b0;
      pkt_cnt_q     <= 16'd0;
      err_cnt_q     <= 8'd0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      rx_ready_q    <= rx_ready_d;
      brd_data_q    <= brd_data_d;
      brd_valid_q   <= brd_valid_d;
      brd_changed_q <= brd_changed_d;
      overrun_q     <= overrun_d;
      pkt_cnt_q     <= pkt_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign rx_rst      = rst_in | (state_q == ST_RECOVER);
  assign busy        = (state_q != ST_IDLE);
  assign brd_data    = brd_data_q;
  assign brd_valid   = brd_valid_q;
  assign brd_changed = brd_changed_q;
  assign overrun     = overrun_q;
  assign pkt_cnt     = pkt_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule
